// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave terminating the bus into a flat, byte-strobed register array.
// Write channel accepts AW and W independently; the read channel runs on its own FSM.
//   state  | meaning
//   W_IDLE | collecting AW and W; write commits on the edge that captures the second
//   W_RESP | bvalid/bresp held until bready
//   R_IDLE | arready high, waiting for AR
//   R_DATA | rvalid/rdata/rresp held until rready
module axi4_lite_slave_regfile #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 8,
  parameter int P_NUM_REGS   = 16
) (
  input  logic                               clk,
  input  logic                               arst_n,
  input  logic                               awvalid,
  output logic                               awready,
  input  logic [P_ADDR_WIDTH-1:0]            awaddr,
  input  logic [2:0]                         awprot,
  input  logic                               wvalid,
  output logic                               wready,
  input  logic [P_DATA_WIDTH-1:0]            wdata,
  input  logic [P_DATA_WIDTH/8-1:0]          wstrb,
  output logic                               bvalid,
  input  logic                               bready,
  output logic [1:0]                         bresp,
  input  logic                               arvalid,
  output logic                               arready,
  input  logic [P_ADDR_WIDTH-1:0]            araddr,
  input  logic [2:0]                         arprot,
  output logic                               rvalid,
  input  logic                               rready,
  output logic [P_DATA_WIDTH-1:0]            rdata,
  output logic [1:0]                         rresp,
  output logic [P_NUM_REGS*P_DATA_WIDTH-1:0] regs_o
);

  localparam int STRB_W   = P_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = P_ADDR_WIDTH - ADDR_LSB;
  localparam logic [IDX_W:0] NUM_REGS_C = (IDX_W+1)'(P_NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [P_DATA_WIDTH-1:0] regs [P_NUM_REGS];

  w_state_t                w_state, w_state_nxt;
  logic                    aw_held, w_held, aw_held_nxt, w_held_nxt;
  logic [IDX_W-1:0]        aw_idx_q;
  logic [P_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic                    aw_hs, w_hs, wr_commit, wr_in_range;
  logic [IDX_W-1:0]        wr_idx;
  logic [P_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]       wr_strb;
  logic                    awready_nxt, wready_nxt, bvalid_nxt;
  logic [1:0]              bresp_nxt;

  r_state_t                r_state, r_state_nxt;
  logic                    ar_hs, rd_in_range, arready_nxt, rvalid_nxt;
  logic [IDX_W-1:0]        rd_idx;
  logic [P_DATA_WIDTH-1:0] rd_word, rdata_nxt;
  logic [1:0]              rresp_nxt;

  logic unused_inputs;
  assign unused_inputs = ^{awprot, arprot, awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

  // Same-edge handshakes bypass the capture registers so the commit sees fresh AW/W.
  always_comb begin
    aw_hs       = awvalid & awready;
    w_hs        = wvalid & wready;
    wr_idx      = aw_hs ? awaddr[P_ADDR_WIDTH-1:ADDR_LSB] : aw_idx_q;
    wr_data     = w_hs ? wdata : wdata_q;
    wr_strb     = w_hs ? wstrb : wstrb_q;
    wr_in_range = {1'b0, wr_idx} < NUM_REGS_C;
    wr_commit   = 1'b0;
    w_state_nxt = w_state;
    aw_held_nxt = aw_held;
    w_held_nxt  = w_held;
    awready_nxt = awready;
    wready_nxt  = wready;
    bvalid_nxt  = bvalid;
    bresp_nxt   = bresp;
    case (w_state)
      W_IDLE: begin
        aw_held_nxt = aw_held | aw_hs;
        w_held_nxt  = w_held | w_hs;
        if (aw_held_nxt && w_held_nxt) begin
          wr_commit   = 1'b1;
          w_state_nxt = W_RESP;
          aw_held_nxt = 1'b0;
          w_held_nxt  = 1'b0;
          awready_nxt = 1'b0;
          wready_nxt  = 1'b0;
          bvalid_nxt  = 1'b1;
          bresp_nxt   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end else begin
          awready_nxt = ~aw_held_nxt;
          wready_nxt  = ~w_held_nxt;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_nxt = W_IDLE;
          bvalid_nxt  = 1'b0;
          awready_nxt = 1'b1;
          wready_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      w_state  <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= 2'b00;
    end else begin
      w_state <= w_state_nxt;
      aw_held <= aw_held_nxt;
      w_held  <= w_held_nxt;
      if (aw_hs) aw_idx_q <= awaddr[P_ADDR_WIDTH-1:ADDR_LSB];
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      awready <= awready_nxt;
      wready  <= wready_nxt;
      bvalid  <= bvalid_nxt;
      bresp   <= bresp_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < P_NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_commit && wr_in_range) begin
      for (int i = 0; i < P_NUM_REGS; i++)
        for (int k = 0; k < STRB_W; k++)
          if (wr_idx == IDX_W'(i) && wr_strb[k]) regs[i][k*8 +: 8] <= wr_data[k*8 +: 8];
    end
  end

  for (genvar gi = 0; gi < P_NUM_REGS; gi++) begin : g_flat
    assign regs_o[gi*P_DATA_WIDTH +: P_DATA_WIDTH] = regs[gi];
  end

  // Read samples the array before any same-edge write lands.
  always_comb begin
    ar_hs       = arvalid & arready;
    rd_idx      = araddr[P_ADDR_WIDTH-1:ADDR_LSB];
    rd_in_range = {1'b0, rd_idx} < NUM_REGS_C;
    rd_word     = '0;
    for (int i = 0; i < P_NUM_REGS; i++)
      if (rd_idx == IDX_W'(i)) rd_word = regs[i];
    r_state_nxt = r_state;
    arready_nxt = arready;
    rvalid_nxt  = rvalid;
    rdata_nxt   = rdata;
    rresp_nxt   = rresp;
    case (r_state)
      R_IDLE: begin
        arready_nxt = 1'b1;
        if (ar_hs) begin
          r_state_nxt = R_DATA;
          arready_nxt = 1'b0;
          rvalid_nxt  = 1'b1;
          rdata_nxt   = rd_in_range ? rd_word : '0;
          rresp_nxt   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (rready) begin
          r_state_nxt = R_IDLE;
          arready_nxt = 1'b1;
          rvalid_nxt  = 1'b0;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= 2'b00;
    end else begin
      r_state <= r_state_nxt;
      arready <= arready_nxt;
      rvalid  <= rvalid_nxt;
      rdata   <= rdata_nxt;
      rresp   <= rresp_nxt;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed and randomized bench for axi4_lite_slave_regfile against an array model.
module tb_axi4_lite_slave_regfile;
  localparam int NREG = 16;

  logic                 clk = 1'b0;
  logic                 arst_n;
  logic                 awvalid, awready, wvalid, wready, bvalid, bready;
  logic [7:0]           awaddr, araddr;
  logic [2:0]           awprot, arprot;
  logic [31:0]          wdata, rdata;
  logic [3:0]           wstrb;
  logic [1:0]           bresp, rresp;
  logic                 arvalid, arready, rvalid, rready;
  logic [NREG*32-1:0]   regs_o;

  logic [31:0] model [NREG];
  int checks = 0;
  int errors = 0;

  axi4_lite_slave_regfile #(.P_DATA_WIDTH(32), .P_ADDR_WIDTH(8), .P_NUM_REGS(NREG)) dut (
    .clk(clk), .arst_n(arst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .regs_o(regs_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    int idx = int'(addr) / 4;
    if (idx >= NREG) return 2'b10;
    for (int k = 0; k < 4; k++)
      if (strb[k]) model[idx][k*8 +: 8] = data[k*8 +: 8];
    return 2'b00;
  endfunction

  function automatic logic [NREG*32-1:0] model_flat();
    logic [NREG*32-1:0] f;
    for (int i = 0; i < NREG; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) model[i] = 32'h0;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_start, input int w_start, input int bhold);
    bit aw_pend = 1, w_pend = 1, aw_fire, w_fire;
    int cyc = 0;
    logic [1:0] exp_resp;
    awaddr = addr; wdata = data; wstrb = strb; awprot = 3'($urandom);
    while ((aw_pend || w_pend) && cyc < 50) begin
      awvalid = aw_pend && (cyc >= aw_start);
      wvalid  = w_pend && (cyc >= w_start);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      tick();
      cyc++;
      if (aw_fire) aw_pend = 0;
      if (w_fire) w_pend = 0;
      if (!aw_pend && w_pend) chk("awready_held", awready, 1'b0);
      if (aw_pend && !w_pend) chk("wready_held", wready, 1'b0);
    end
    awvalid = 0; wvalid = 0;
    chk("write_accepted", {aw_pend, w_pend}, 2'b00);
    exp_resp = model_write(addr, data, strb);
    chk("bvalid_latency", bvalid, 1'b1);
    chk("bresp", bresp, exp_resp);
    chk("regs_after_write", regs_o, model_flat());
    repeat (bhold) begin
      tick();
      chk("bvalid_hold", bvalid, 1'b1);
      chk("bresp_hold", bresp, exp_resp);
      chk("awready_during_b", awready, 1'b0);
    end
    bready = 1;
    tick();
    bready = 0;
    chk("bvalid_clear", bvalid, 1'b0);
    chk("ready_after_b", {awready, wready}, 2'b11);
  endtask

  task automatic do_read(input logic [7:0] addr, input int rhold);
    bit fired = 0;
    int cyc = 0;
    int idx = int'(addr) / 4;
    logic [31:0] exp_data = (idx < NREG) ? model[idx] : 32'h0;
    logic [1:0]  exp_resp = (idx < NREG) ? 2'b00 : 2'b10;
    araddr = addr; arprot = 3'($urandom); arvalid = 1;
    while (!fired && cyc < 50) begin
      fired = arready;
      tick();
      cyc++;
    end
    arvalid = 0;
    chk("read_accepted", fired, 1'b1);
    chk("rvalid_latency", rvalid, 1'b1);
    chk("rdata", rdata, exp_data);
    chk("rresp", rresp, exp_resp);
    repeat (rhold) begin
      tick();
      chk("rdata_hold", {rvalid, rdata, rresp}, {1'b1, exp_data, exp_resp});
      chk("arready_during_r", arready, 1'b0);
    end
    rready = 1;
    tick();
    rready = 0;
    chk("rvalid_clear", rvalid, 1'b0);
    chk("arready_after_r", arready, 1'b1);
  endtask

  initial begin
    logic [31:0] d1, d2, old;
    logic [1:0]  r;
    arst_n = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; awprot = 0; arprot = 0; wdata = 0; wstrb = 0;
    model_clear();

    // Reset state
    repeat (3) tick();
    chk("reset_ready", {awready, wready, arready}, 3'b000);
    chk("reset_valid", {bvalid, rvalid}, 2'b00);
    chk("reset_resp_data", {bresp, rresp, rdata}, 36'h0);
    chk("reset_regs", regs_o, model_flat());
    arst_n = 1;
    tick();
    chk("ready_after_reset", {awready, wready, arready}, 3'b111);

    // Basic write/read, same-cycle AW/W
    do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    chk("reg1_deadbeef", regs_o[32 +: 32], 32'hDEADBEEF);
    do_read(8'h04, 0);

    // AW three cycles before W, then W three cycles before AW
    do_write(8'h08, 32'h11223344, 4'hF, 0, 3, 0);
    do_read(8'h08, 1);
    do_write(8'h08, 32'h55667788, 4'hF, 3, 0, 0);
    do_read(8'h09, 0);

    // Byte strobes
    do_write(8'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(8'h0C, 32'h00000000, 4'b0101, 0, 0, 0);
    chk("strobe_merge", regs_o[96 +: 32], 32'hFF00FF00);
    do_read(8'h0C, 0);

    // Out of range
    do_write(8'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    do_read(8'h40, 0);

    // bready held low while a new AW/W waits
    d1 = $urandom; d2 = $urandom;
    awaddr = 8'h14; wdata = d1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick();
    r = model_write(8'h14, d1, 4'hF);
    chk("bp_first_commit", {bvalid, bresp}, {1'b1, r});
    awaddr = 8'h18; wdata = d2;
    repeat (5) begin
      tick();
      chk("bp_bvalid_stable", {bvalid, bresp}, {1'b1, r});
      chk("bp_no_accept", {awready, wready}, 2'b00);
      chk("bp_regs", regs_o, model_flat());
    end
    bready = 1;
    tick();
    bready = 0;
    chk("bp_after_handshake", {bvalid, awready, wready}, 3'b011);
    chk("bp_not_captured", regs_o, model_flat());
    tick();
    awvalid = 0; wvalid = 0;
    r = model_write(8'h18, d2, 4'hF);
    chk("bp_second_commit", {bvalid, bresp}, {1'b1, r});
    chk("bp_second_regs", regs_o, model_flat());
    bready = 1;
    tick();
    bready = 0;
    chk("bp_second_clear", bvalid, 1'b0);

    // Stale AW discarded by reset
    awaddr = 8'h08; awvalid = 1;
    tick();
    awvalid = 0;
    chk("stale_aw_captured", awready, 1'b0);
    arst_n = 0;
    tick();
    arst_n = 1;
    model_clear();
    chk("midreset_regs", regs_o, model_flat());
    chk("midreset_valid", {bvalid, rvalid}, 2'b00);
    tick();
    do_write(8'h00, $urandom, 4'hF, 2, 0, 0);
    do_read(8'h08, 0);

    // AR on the same edge as a write commit returns the old value
    do_write(8'h04, $urandom, 4'hF, 0, 0, 0);
    old = model[1];
    d1 = ~old;
    chk("same_edge_ready", {awready, wready, arready}, 3'b111);
    awaddr = 8'h04; wdata = d1; wstrb = 4'hF; araddr = 8'h04;
    awvalid = 1; wvalid = 1; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    r = model_write(8'h04, d1, 4'hF);
    chk("same_edge_valids", {bvalid, rvalid}, 2'b11);
    chk("same_edge_rdata", rdata, old);
    chk("same_edge_regs", regs_o, model_flat());
    bready = 1; rready = 1;
    tick();
    bready = 0; rready = 0;
    chk("same_edge_clear", {bvalid, rvalid}, 2'b00);

    // Randomized mix
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(8'($urandom_range(0, 8'h4F)), $urandom, 4'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      else
        do_read(8'($urandom_range(0, 8'h4F)), int'($urandom_range(0, 2)));
    end
    chk("final_regs", regs_o, model_flat());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
